// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: drives freeze/clr of the FD, DE, EM, MW banks and the PC.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic             ld_use_hazard,
  input  logic             branch_taken_EX,
  input  logic             imem_stall,
  input  logic             dmem_req,
  input  logic             dmem_done,
  input  logic             dump_EM,
  output logic             pc_freeze,
  output logic             freeze_FD,
  output logic             freeze_DE,
  output logic             freeze_EM,
  output logic             freeze_MW,
  output logic             clr_FD,
  output logic             clr_DE,
  output logic             clr_EM,
  output logic             clr_MW,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, DMEM_WAIT, DRAIN, HALT} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] drain_cnt, drain_nxt;
  logic       mem_wait;
  logic       pc_r, ffd_r, fde_r, fem_r, fmw_r, cfd_r, cde_r, cem_r, cmw_r, halt_r;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // DMEM_WAIT holds the row-1 stall until done, whatever dmem_req does meanwhile.
  assign mem_wait = (state == DMEM_WAIT) ? !dmem_done : (dmem_req && !dmem_done);

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    pc_r  = 1'b0; ffd_r = 1'b0; fde_r = 1'b0; fem_r = 1'b0; fmw_r = 1'b0;
    cfd_r = 1'b0; cde_r = 1'b0; cem_r = 1'b0; cmw_r = 1'b0; halt_r = 1'b0;
    case (state)
      RUN, DMEM_WAIT: begin
        state_nxt = RUN;
        if (mem_wait) begin
          pc_r = 1'b1; ffd_r = 1'b1; fde_r = 1'b1; fem_r = 1'b1; cmw_r = 1'b1;
          state_nxt = DMEM_WAIT;
        end else if (dump_EM) begin
          pc_r = 1'b1; ffd_r = 1'b1; cde_r = 1'b1; cem_r = 1'b1;
          state_nxt = DRAIN;
          drain_nxt = 3'd0;
        end else if (branch_taken_EX) begin
          // Wrong-path load-use and fetch stalls are discarded by the flush.
          cfd_r = 1'b1; cde_r = 1'b1;
        end else if (ld_use_hazard) begin
          pc_r = 1'b1; ffd_r = 1'b1; cde_r = 1'b1;
        end else if (imem_stall) begin
          pc_r = 1'b1; cfd_r = 1'b1;
        end
      end
      DRAIN: begin
        pc_r = 1'b1; ffd_r = 1'b1; fde_r = 1'b1; cem_r = 1'b1; cmw_r = 1'b1;
        drain_nxt = drain_cnt + 3'd1;
        if (drain_cnt >= DRAIN_LAST) state_nxt = HALT;
      end
      HALT: begin
        pc_r = 1'b1; ffd_r = 1'b1; fde_r = 1'b1; fem_r = 1'b1; fmw_r = 1'b1;
        halt_r = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pc_freeze = pc_r   & ~global_rst;
  assign freeze_FD = ffd_r  & ~global_rst;
  assign freeze_DE = fde_r  & ~global_rst;
  assign freeze_EM = fem_r  & ~global_rst;
  assign freeze_MW = fmw_r  & ~global_rst;
  assign clr_FD    = cfd_r  & ~global_rst;
  assign clr_DE    = cde_r  & ~global_rst;
  assign clr_EM    = cem_r  & ~global_rst;
  assign clr_MW    = cmw_r  & ~global_rst;
  assign halted    = halt_r & ~global_rst;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_fire;

  // clr_FD together with clr_DE only occurs for a taken-branch flush.
  assign flush_fire = clr_FD & clr_DE;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_freeze && !halted && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_fire && flush_q != '1)           flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the `freeze` and `local_clr` inputs of the four inter-stage flop banks (FD, DE, EM, MW) and the PC freeze. Inputs are load-use hazards, taken branches, instruction- and data-memory stalls, and the halt (`dump`) instruction. It owns the multi-cycle data-memory wait and the halt-drain sequence, and sits beside the decode/execute hazard-detection logic in the top-level processor.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles spent in DRAIN after the dump leaves M, before HALT; legal range 1–7.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `global_rst` input 1: asynchronous, active-high reset.
- `ld_use_hazard` input 1: instruction in D reads the destination register of a load in DE.
- `branch_taken_EX` input 1: redirect resolved in EX this cycle.
- `imem_stall` input 1: instruction memory has no valid fetch this cycle.
- `dmem_req` input 1: valid memory operation in M (EM `mem_enable` output).
- `dmem_done` input 1: data memory completes the M access this cycle.
- `dump_EM` input 1: halt instruction in M.
- `pc_freeze` output 1: hold the PC.
- `freeze_FD`, `freeze_DE`, `freeze_EM`, `freeze_MW` output 1 each: hold the corresponding flop bank.
- `clr_FD`, `clr_DE`, `clr_EM`, `clr_MW` output 1 each: load a bubble (`local_clr`) into the corresponding bank.
- `halted` output 1: processor halted.
- `stall_cycles` output CNT_W: count of cycles with `pc_freeze`=1.
- `flush_count` output CNT_W: count of taken-branch flushes.

## Operation
- States: RUN, DMEM_WAIT, DRAIN, HALT. The state is registered. All freeze/clr outputs are combinational from the current state and inputs (Mealy), so stalls take effect at the next edge.
- RUN uses priority decode; the first matching row wins:
  1. **Data-memory stall**: `dmem_req`=1 and `dmem_done`=0. Assert `pc_freeze`, `freeze_FD`, `freeze_DE`, `freeze_EM` and `clr_MW`. Next state is DMEM_WAIT.
  2. **Dump**: `dump_EM`=1. Assert `pc_freeze`, `freeze_FD`, `clr_DE` and `clr_EM`; MW advances with the dump. Next state is DRAIN, with the drain counter set to 0.
  3. **Taken branch**: `branch_taken_EX`=1. Assert `clr_FD` and `clr_DE`. The PC loads the target.
  4. **Load-use hazard**: `ld_use_hazard`=1. Assert `pc_freeze`, `freeze_FD` and `clr_DE`.
  5. **Instruction-memory stall**: `imem_stall`=1. Assert `pc_freeze` and `clr_FD`.
  6. Otherwise, all outputs are 0.
- DMEM_WAIT:
  - While `dmem_done`=0, drive the same outputs as row 1.
  - When `dmem_done`=1, release all freezes. The same cycle decodes rows 2–6 on the current inputs, then returns to RUN.
- DRAIN:
  - Every cycle assert `pc_freeze`, `freeze_FD`, `freeze_DE`, `clr_EM` and `clr_MW`.
  - The counter increments each cycle; after DRAIN_CYCLES cycles the next state is HALT.
  - All other inputs are ignored.
- HALT:
  - Assert `pc_freeze` and all four `freeze_*`; assert `halted`=1.
  - All inputs are ignored. Only `global_rst` exits HALT.
- A register bank never sees its freeze and clr asserted together.

## Timing
- Reset, asynchronous: state goes to RUN, the drain counter and both perf counters go to 0.
  - While `global_rst`=1, every output is forced to 0.
- Latency: every output responds combinationally in the same cycle as its inputs. No added pipeline latency.
- Data-memory stall: `dmem_done` first asserted at cycle T+k means the M instruction advances at the edge ending cycle T+k, and RUN is resumed at T+k+1.
  - `dmem_done`=1 in the same cycle as the request means no stall and no state change.
- Dump seen in M at cycle T:
  - DRAIN occupies cycles T+1 through T+DRAIN_CYCLES.
  - `halted` rises at cycle T+DRAIN_CYCLES+1.
- A simultaneous branch and load-use hazard produces the flush only: the wrong-path load-use is discarded and the PC does not freeze.
- A reset asserted mid-DMEM_WAIT or mid-DRAIN aborts the sequence immediately. There is no pending state after reset.

## Configuration
- Macro `PIPE_CTRL_PERF_CNT_EN`.
- **Defined**:
  - `stall_cycles` increments on every cycle with `pc_freeze`=1 and `halted`=0.
  - `flush_count` increments on every cycle where row 3 fires.
  - Both counters saturate at 2^CNT_W−1 and clear only on reset.
- **Undefined**: no counter flops; both ports are tied to 0. The port list is identical in both builds.

## Test plan
- **Load-use**: reset, then `ld_use_hazard`=1 for 1 cycle → `pc_freeze`=`freeze_FD`=`clr_DE`=1 for exactly that cycle; `stall_cycles`=1 (with `PIPE_CTRL_PERF_CNT_EN`).
- **Data-memory wait**: `dmem_req`=1 with `dmem_done` low for 3 cycles, then high → PC/FD/DE/EM frozen and `clr_MW`=1 for 3 cycles; all released on the done cycle; state is RUN on the next cycle.
- **Branch priority**: `branch_taken_EX`=1, `ld_use_hazard`=1, `imem_stall`=1 together → only `clr_FD`=`clr_DE`=1, `pc_freeze`=0; `flush_count` increments by 1.
- **Halt drain**: `dump_EM`=1 at cycle 10, DRAIN_CYCLES=2 → `clr_DE`=`clr_EM`=1 at cycle 10; `halted`=1 from cycle 13 onward; later `branch_taken_EX`/`dmem_req` pulses produce no output change.
- **Reset mid-wait**: assert `global_rst` asynchronously mid-cycle during DMEM_WAIT → all outputs 0 immediately; after release, `dmem_req`=0 gives all outputs 0 with state RUN.
- **Saturation**: CNT_W=4, `imem_stall` held high for 20 cycles → `stall_cycles` stops at 15.
